// File: rtl/window_pkg.sv
// Shared definitions for the register-window controller.
// Holds the operation codes, the window trap type codes and the
// controller FSM state encoding. No ports.
package window_pkg;

   localparam logic [1:0] OP_SAVE    = 2'b00;
   localparam logic [1:0] OP_RESTORE = 2'b01;
   localparam logic [1:0] OP_WRCWP   = 2'b10;
   localparam logic [1:0] OP_WRWIM   = 2'b11;

   localparam logic [7:0] TT_NONE    = 8'h00;
   localparam logic [7:0] TT_WIN_OVF = 8'h05;
   localparam logic [7:0] TT_WIN_UNF = 8'h06;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_CHECK     = 2'd1,
      ST_TRAP_WAIT = 2'd2,
      ST_DONE      = 2'd3
   } state_e;

endpackage

// File: rtl/window_step.sv
// Combinational window stepper.
// Returns the neighbouring window of cwp_i (inc_i=1: +1, inc_i=0: -1),
// modulo NWINDOWS, and whether that window is marked invalid in wim_i.
// Ports:
//   cwp_i     - current window pointer
//   inc_i     - direction: 1 increment (RESTORE), 0 decrement (SAVE / trap entry)
//   wim_i     - window invalid mask
//   nxt_o     - neighbouring window
//   invalid_o - wim_i[nxt_o]
module window_step #(
   parameter int NWINDOWS = 4,
   parameter int CWP_W    = 2
) (
   input  logic [CWP_W-1:0]    cwp_i,
   input  logic                inc_i,
   input  logic [NWINDOWS-1:0] wim_i,
   output logic [CWP_W-1:0]    nxt_o,
   output logic                invalid_o
);

   // NWINDOWS is a power of two, so CWP_W-bit arithmetic wraps modulo NWINDOWS.
   assign nxt_o     = inc_i ? (cwp_i + CWP_W'(1)) : (cwp_i - CWP_W'(1));
   assign invalid_o = wim_i[nxt_o];

endmodule

// File: rtl/window_ctrl.sv
// Register-window controller: sequences SAVE, RESTORE, WRCWP and WRWIM,
// owns CWP/WIM, raises window overflow/underflow traps and performs the
// trap-entry CWP decrement once the trap unit acknowledges.
// Ports:
//   clk_i       - clock, all state changes on rising edge
//   clr_i       - synchronous active-high reset, highest priority
//   op_valid_i  - operation request, sampled only while idle
//   op_code_i   - 00 SAVE, 01 RESTORE, 10 WRCWP, 11 WRWIM
//   wr_data_i   - operand for WRCWP / WRWIM
//   trap_ack_i  - trap unit accepts the pending window trap
//   busy_o      - operation in progress, requests ignored
//   op_done_o   - one-cycle pulse when an operation retires
//   cwp_o       - current window pointer
//   wim_o       - window invalid mask
//   trap_req_o  - window trap pending, held until trap_ack_i
//   trap_type_o - trap type of the last accepted operation (0 if none)
module window_ctrl
   import window_pkg::*;
#(
   parameter int                  NWINDOWS  = 4,
   parameter int                  CWP_W     = 2,
   parameter logic [NWINDOWS-1:0] RESET_WIM = 4'b0010
) (
   input  logic                clk_i,
   input  logic                clr_i,
   input  logic                op_valid_i,
   input  logic [1:0]          op_code_i,
   input  logic [31:0]         wr_data_i,
   input  logic                trap_ack_i,
   output logic                busy_o,
   output logic                op_done_o,
   output logic [CWP_W-1:0]    cwp_o,
   output logic [NWINDOWS-1:0] wim_o,
   output logic                trap_req_o,
   output logic [7:0]          trap_type_o
);

   state_e              state_q;
   logic [1:0]          op_q;
   logic [NWINDOWS-1:0] data_q;
   logic [CWP_W-1:0]    cwp_q;
   logic [NWINDOWS-1:0] wim_q;
   logic                busy_q;
   logic                op_done_q;
   logic                trap_req_q;
   logic [7:0]          trap_type_q;

   logic                step_inc_s;
   logic [CWP_W-1:0]    step_nxt_s;
   logic                step_invalid_s;

   // Only RESTORE in CHECK steps upward; SAVE and trap entry both step down.
   assign step_inc_s = (state_q == ST_CHECK) && (op_q == OP_RESTORE);

   window_step #(
      .NWINDOWS (NWINDOWS),
      .CWP_W    (CWP_W)
   ) u_step (
      .cwp_i     (cwp_q),
      .inc_i     (step_inc_s),
      .wim_i     (wim_q),
      .nxt_o     (step_nxt_s),
      .invalid_o (step_invalid_s)
   );

   // Operand bits above the WIM width are never used by any operation.
   if (NWINDOWS < 32) begin : g_unused
      logic unused_s;
      assign unused_s = ^wr_data_i[31:NWINDOWS];
   end

   // Controller FSM with all outputs registered.
   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_SAVE;
         data_q      <= '0;
         cwp_q       <= '0;
         wim_q       <= RESET_WIM;
         busy_q      <= 1'b0;
         op_done_q   <= 1'b0;
         trap_req_q  <= 1'b0;
         trap_type_q <= TT_NONE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               op_done_q <= 1'b0;
               if (op_valid_i) begin
                  op_q        <= op_code_i;
                  data_q      <= wr_data_i[NWINDOWS-1:0];
                  busy_q      <= 1'b1;
                  trap_type_q <= TT_NONE;
                  state_q     <= ST_CHECK;
               end else begin
                  busy_q <= 1'b0;
               end
            end
            ST_CHECK: begin
               case (op_q)
                  OP_SAVE, OP_RESTORE: begin
                     if (step_invalid_s) begin
                        trap_type_q <= (op_q == OP_SAVE) ? TT_WIN_OVF : TT_WIN_UNF;
                        trap_req_q  <= 1'b1;
                        state_q     <= ST_TRAP_WAIT;
                     end else begin
                        cwp_q     <= step_nxt_s;
                        op_done_q <= 1'b1;
                        state_q   <= ST_DONE;
                     end
                  end
                  OP_WRCWP: begin
                     cwp_q     <= data_q[CWP_W-1:0];
                     op_done_q <= 1'b1;
                     state_q   <= ST_DONE;
                  end
                  OP_WRWIM: begin
                     wim_q     <= data_q;
                     op_done_q <= 1'b1;
                     state_q   <= ST_DONE;
                  end
                  default: begin
                     op_done_q <= 1'b1;
                     state_q   <= ST_DONE;
                  end
               endcase
            end
            ST_TRAP_WAIT: begin
               // Trap entry rotates CWP down without consulting WIM.
               if (trap_ack_i) begin
                  cwp_q      <= step_nxt_s;
                  trap_req_q <= 1'b0;
                  op_done_q  <= 1'b1;
                  state_q    <= ST_DONE;
               end else begin
                  trap_req_q <= 1'b1;
               end
            end
            ST_DONE: begin
               op_done_q <= 1'b0;
               busy_q    <= 1'b0;
               state_q   <= ST_IDLE;
            end
            default: begin
               op_done_q  <= 1'b0;
               busy_q     <= 1'b0;
               trap_req_q <= 1'b0;
               state_q    <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy_o      = busy_q;
   assign op_done_o   = op_done_q;
   assign cwp_o       = cwp_q;
   assign wim_o       = wim_q;
   assign trap_req_o  = trap_req_q;
   assign trap_type_o = trap_type_q;

endmodule
